// File: rtl/spi_sampler_pkg.sv
// Shared types and constants for the SPI-controller polling sampler.
// Holds the sampler FSM states, APB phase encoding and register offsets.
// No logic: purely declarations imported by the sampler and its APB sequencer.
package spi_sampler_pkg;

  localparam int unsigned APB_AW = 7;
  localparam int unsigned CH_W   = 6;

  localparam logic [APB_AW-1:0] OFS_CTRL   = 7'h00;
  localparam logic [APB_AW-1:0] OFS_RXDATA = 7'h08;
  localparam logic [APB_AW-1:0] OFS_TXDATA = 7'h0C;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_TX_WAIT,
    ST_TX_SETUP,
    ST_TX_ACC,
    ST_RX_WAIT,
    ST_RX_SETUP,
    ST_RX_ACC,
    ST_EMIT
  } state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_phase_e;

endpackage

// File: rtl/apb_master_if.sv
// Single-access APB sequencer: req launches one SETUP then ACCESS transfer.
// Latency: PSEL rises the cycle after req; done pulses on the ACCESS cycle with PREADY=1.
// Backpressure: ACCESS is held (address/data stable) while PREADY=0; req only sampled when idle.
module apb_master_if
  import spi_sampler_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              req,
  input  logic              wr,
  input  logic [APB_AW-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic              done,
  output logic [DW-1:0]     rdata,
  output logic [APB_AW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DW-1:0]     PWDATA,
  input  logic [DW-1:0]     PRDATA,
  input  logic              PREADY
);

  apb_phase_e        phase_q, phase_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;

  // Phase sequencing; address/data/direction latched once at request time.
  always_comb begin
    phase_d  = phase_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    case (phase_q)
      APB_IDLE: begin
        if (req) begin
          phase_d  = APB_SETUP;
          paddr_d  = addr;
          pwrite_d = wr;
          pwdata_d = wdata;
        end
      end
      APB_SETUP:  phase_d = APB_ACCESS;
      APB_ACCESS: if (PREADY) phase_d = APB_IDLE;
      default:    phase_d = APB_IDLE;
    endcase
    // Separate flops for PSEL/PENABLE keep the bus strobes glitch-free.
    psel_d    = (phase_d != APB_IDLE);
    penable_d = (phase_d == APB_ACCESS);
  end

  // Bus state registers; reset drops PSEL/PENABLE immediately.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      phase_q   <= APB_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign done    = (phase_q == APB_ACCESS) && PREADY;
  assign rdata   = PRDATA;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: rtl/spi_apb_sampler.sv
// APB master polling an SPI controller: one command write and one reply read per channel per frame.
// Latency: first PSEL 1 cycle after frame_trig (TX room available); 6 cycles per channel minimum.
// Backpressure: sample held on m_valid until m_ready; no APB traffic meanwhile; PREADY stalls honoured.
module spi_apb_sampler
  import spi_sampler_pkg::*;
#(
  parameter int unsigned           APB_DWIDTH  = 8,
  parameter int unsigned           NUM_CH      = 16,
  parameter logic [APB_DWIDTH-1:0] CMD_BASE    = '0,
  parameter logic [APB_DWIDTH-1:0] CTRL_VAL    = APB_DWIDTH'(3),
  parameter logic [APB_AW-1:0]     ADDR_CTRL   = OFS_CTRL,
  parameter logic [APB_AW-1:0]     ADDR_RXDATA = OFS_RXDATA,
  parameter logic [APB_AW-1:0]     ADDR_TXDATA = OFS_TXDATA,
  parameter int unsigned           TO_CYCLES   = 1023
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  frame_trig,
  output logic [APB_AW-1:0]     PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  SPITXRFM,
  input  logic                  SPIRXAVAIL,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [APB_DWIDTH-1:0] m_data,
  output logic [CH_W-1:0]       m_chan,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int unsigned     TO_W    = $clog2(TO_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [TO_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic                    init_sent_q, init_sent_d;
  logic                    m_valid_q, m_valid_d;
  logic [APB_DWIDTH-1:0]   m_data_q, m_data_d;
  logic [CH_W-1:0]         m_chan_q, m_chan_d;
  logic                    m_last_q, m_last_d;

  logic                    apb_req, apb_wr, apb_done;
  logic [APB_AW-1:0]       apb_addr;
  logic [APB_DWIDTH-1:0]   apb_wdata, apb_rdata;

  apb_master_if #(.DW(APB_DWIDTH)) u_apb (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .req     (apb_req),
    .wr      (apb_wr),
    .addr    (apb_addr),
    .wdata   (apb_wdata),
    .done    (apb_done),
    .rdata   (apb_rdata),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  assign cnt_inc = cnt_q + TO_W'(1);

  // Frame sequencing, APB request generation, reply timeout and sample capture.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    timeout_d   = 1'b0;
    init_sent_d = init_sent_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_chan_d    = m_chan_q;
    m_last_d    = m_last_q;
    apb_req     = 1'b0;
    apb_wr      = 1'b0;
    apb_addr    = ADDR_CTRL;
    apb_wdata   = '0;

    // A trigger is only accepted in IDLE; anywhere else it is dropped and flagged.
    if (frame_trig && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_INIT: begin
        if (!init_sent_q) begin
          apb_req     = 1'b1;
          apb_wr      = 1'b1;
          apb_addr    = ADDR_CTRL;
          apb_wdata   = CTRL_VAL;
          init_sent_d = 1'b1;
        end
        if (apb_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (frame_trig) begin
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT:  ;  // launch handled below, shared with IDLE/EMIT entry
      ST_TX_SETUP: state_d = ST_TX_ACC;
      ST_TX_ACC: begin
        if (apb_done) begin
          cnt_d   = '0;
          state_d = ST_RX_WAIT;
        end
      end
      ST_RX_WAIT: begin
        if (SPIRXAVAIL) begin
          cnt_d    = '0;
          apb_req  = 1'b1;
          apb_addr = ADDR_RXDATA;
          state_d  = ST_RX_SETUP;
        end else if (cnt_inc == TO_W'(TO_CYCLES)) begin
          // No reply: emit a zero so downstream still sees a full frame.
          cnt_d     = '0;
          timeout_d = 1'b1;
          m_valid_d = 1'b1;
          m_data_d  = '0;
          m_chan_d  = ch_q;
          m_last_d  = (ch_q == LAST_CH);
          state_d   = ST_EMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RX_SETUP: state_d = ST_RX_ACC;
      ST_RX_ACC: begin
        if (apb_done) begin
          m_valid_d = 1'b1;
          m_data_d  = apb_rdata;
          m_chan_d  = ch_q;
          m_last_d  = (ch_q == LAST_CH);
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_TX_WAIT;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    // TX_WAIT costs no cycle when the TX FIFO already has room.
    if ((state_d == ST_TX_WAIT) && SPITXRFM) begin
      apb_req   = 1'b1;
      apb_wr    = 1'b1;
      apb_addr  = ADDR_TXDATA;
      apb_wdata = CMD_BASE + APB_DWIDTH'(ch_d);
      state_d   = ST_TX_SETUP;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= ST_INIT;
      ch_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      init_sent_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_chan_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      init_sent_q <= init_sent_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_chan_q    <= m_chan_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign timeout = timeout_q;

endmodule
